binary_code_converter: RTL and testbench

// - Registered 4-bit binary code converter. Each accepted sample BN produces three encodings:
//   - BCD units digit plus a tens flag.
//   - Reflected Gray code.
//   - Even-parity Hamming(7,4) codeword.
// - Sits between a binary source (counter, switch bank) and display or link logic.
// - One sample per clock; fixed 1-cycle latency.
//

---
 rtl/binary_code_converter.sv | 63 ++++++
 tb/tb_binary_code_converter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_code_converter.sv
// Registered 4-bit binary converter: BCD units digit with tens flag, reflected Gray code
// and even-parity Hamming(7,4) codeword, all loaded together with one cycle of latency.
`timescale 1ns/1ps
module binary_code_converter (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] BN,
    output logic       out_valid,
    output logic [3:0] BCD,
    output logic       TENS,
    output logic [3:0] G,
    output logic [6:0] H
);

    // Handshake: in_valid qualifies BN on each rising edge; there is no ready, so every
    // qualified sample is taken. out_valid is high for exactly the one cycle after the edge
    // that took a sample; data outputs hold their last conversion while out_valid is low.

    logic       ge_ten;
    logic [3:0] bn_minus_ten;
    logic [3:0] bcd_next;
    logic [3:0] gray_next;
    logic       d1, d2, d3, d4;
    logic       p1, p2, p4;
    logic [6:0] ham_next;

    // BN-10 wraps modulo 16 and is only selected when BN >= 10, so it never underflows in use.
    assign ge_ten       = BN[3] & (BN[2] | BN[1]);
    assign bn_minus_ten = BN - 4'd10;
    assign bcd_next     = ge_ten ? bn_minus_ten : BN;

    assign gray_next = BN ^ {1'b0, BN[3:1]};

    assign d1 = BN[0];
    assign d2 = BN[1];
    assign d3 = BN[2];
    assign d4 = BN[3];
    assign p1 = d1 ^ d2 ^ d4;
    assign p2 = d1 ^ d3 ^ d4;
    assign p4 = d2 ^ d3 ^ d4;
    // H[k-1] carries codeword position k, parity bits sit at the power-of-two positions.
    assign ham_next = {d4, d3, d2, p4, d1, p2, p1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            BCD       <= 4'd0;
            TENS      <= 1'b0;
            G         <= 4'd0;
            H         <= 7'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                BCD  <= bcd_next;
                TENS <= ge_ten;
                G    <= gray_next;
                H    <= ham_next;
            end
        end
    end

endmodule

// File: tb/tb_binary_code_converter.sv
// Scoreboard bench for binary_code_converter: stimulus pushes expected conversions,
// a negedge monitor pops and compares whenever out_valid is presented.
`timescale 1ns/1ps
module tb_binary_code_converter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] BN = 4'd0;
    logic       out_valid;
    logic [3:0] BCD;
    logic       TENS;
    logic [3:0] G;
    logic [6:0] H;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Packed expectation: [19:16] bn, [15] tens, [14:11] bcd, [10:7] gray, [6:0] hamming
    logic [19:0] exp_q[$];
    int          exp_cyc_q[$];

    logic [3:0] g_tab[16];
    logic [6:0] h_tab[16];
    logic [3:0] obs_g[16];
    logic [6:0] obs_h[16];

    binary_code_converter dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .BN(BN),
        .out_valid(out_valid),
        .BCD(BCD),
        .TENS(TENS),
        .G(G),
        .H(H)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [19:0] make_exp(input logic [3:0] bn);
        logic       tens;
        logic [3:0] bcd;
        tens = (bn >= 4'd10);
        bcd  = tens ? (bn - 4'd10) : bn;
        return {bn, tens, bcd, g_tab[bn], h_tab[bn]};
    endfunction

    task automatic drive(input logic v, input logic [3:0] b);
        @(posedge clk);
        #1;
        in_valid = v;
        BN       = b;
        if (v) begin
            exp_q.push_back(make_exp(b));
            exp_cyc_q.push_back(cyc + 1);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_bcd"}, BCD, 0);
        check({tag, "_tens"}, TENS, 0);
        check({tag, "_g"}, G, 0);
        check({tag, "_h"}, H, 0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                logic [19:0] e;
                int          c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("latency_cycle", cyc, c);
                check("bcd", BCD, e[14:11]);
                check("tens", TENS, e[15]);
                check("gray", G, e[10:7]);
                check("hamming", H, e[6:0]);
                obs_g[e[19:16]] = G;
                obs_h[e[19:16]] = H;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        g_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        h_tab = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                  7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};
        for (int i = 0; i < 16; i++) begin
            obs_g[i] = 4'd0;
            obs_h[i] = 7'd0;
        end

        // Reset asserted before the first clock edge, with a live input present
        in_valid = 1'b1;
        BN       = 4'hF;
        #2 reset = 1'b0;
        #1 check_zero("reset_async");
        repeat (3) @(posedge clk);
        #3 check_zero("reset_held");

        // Release between edges; the first edge afterwards takes BN=15
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q.push_back(make_exp(4'hF));
        exp_cyc_q.push_back(cyc + 1);

        drive(1'b1, 4'd9);
        drive(1'b1, 4'd12);
        drive(1'b1, 4'd0);

        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i));
        drive(1'b0, 4'(i_rand()));
        drain("sweep");

        for (int i = 0; i < 15; i++)
            check($sformatf("gray_step_%0d", i), $countones(obs_g[i] ^ obs_g[i+1]), 1);
        for (int i = 0; i < 16; i++) begin
            logic [6:0] h;
            h = obs_h[i];
            check($sformatf("syndrome_%0d", i),
                  {h[6]^h[5]^h[4]^h[3], h[6]^h[5]^h[2]^h[1], h[6]^h[4]^h[2]^h[0]}, 0);
        end
        for (int i = 0; i < 16; i++)
            for (int j = i + 1; j < 16; j++)
                check($sformatf("hdist_%0d_%0d", i, j),
                      ($countones(obs_h[i] ^ obs_h[j]) >= 3), 1);

        // Hold: three edges with in_valid low after BN=9, BN wandering meanwhile
        drive(1'b1, 4'd9);
        drive(1'b0, 4'(i_rand()));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'(i_rand()));
            #2;
            check("hold_out_valid", out_valid, 0);
            check("hold_bcd", BCD, 4'b1001);
            check("hold_tens", TENS, 0);
            check("hold_g", G, 4'b1101);
            check("hold_h", H, 7'b1001100);
        end
        #1 reset = 1'b0;
        #1 check_zero("reset_mid_hold");
        @(posedge clk);
        #1 reset = 1'b1;

        // Sample presented, then reset before its capture edge: it must never appear
        drive(1'b1, 4'd5);
        #2;
        reset = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1 check_zero("reset_inflight");
        @(posedge clk);
        #2 check_zero("reset_inflight_edge");
        in_valid = 1'b0;
        #1 reset = 1'b1;

        drive(1'b1, 4'd3);
        drive(1'b1, 4'd10);
        drive(1'b0, 4'd0);
        drain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int i_rand();
        return $urandom_range(0, 15);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
